// File: rtl/bp_sched_pkg.sv
// Shared types and default parameters for the branch-predictor update scheduler.
// Contents:
//   arb_state_t - arbitration state. LkPri favours lookups; UpdPri forces one update.
//   upd_entry_t - buffered branch resolution {index, outcome, pred}.
//   is_miss()   - tells whether a buffered resolution was mispredicted.
package bp_sched_pkg;

  localparam int unsigned KDef      = 4;
  localparam int unsigned MDef      = 3;
  localparam int unsigned DepthDef  = 4;
  localparam int unsigned StarveDef = 3;
  localparam int unsigned CwDef     = 16;

  typedef enum logic [0:0] {
    LkPri,
    UpdPri
  } arb_state_t;

  typedef struct packed {
    logic [KDef-1:0] index;
    logic            outcome;
    logic            pred;
  } upd_entry_t;

  function automatic logic is_miss(input upd_entry_t e);
    return e.outcome != e.pred;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Synchronous FIFO of branch resolutions awaiting a PHT update slot.
// Ports:
//   clk, reset         - clock and asynchronous active-low reset
//   push, push_data    - write an entry (ignored while full)
//   pop, pop_data      - read the head entry (ignored while empty)
//   full, empty, count - occupancy status
// The head is read straight from storage, so an entry pushed in cycle t can
// be popped in cycle t+1 at the earliest.
module bp_upd_fifo
  import bp_sched_pkg::*;
#(
  parameter int unsigned DEPTH = DepthDef
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  upd_entry_t                 push_data,
  input  logic                       pop,
  output upd_entry_t                 pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  upd_entry_t    mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   rd_ptr_q;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bp_update_scheduler.sv
// Arbitrates the single PHT port (and the BHR) between fetch lookups and
// buffered execute-stage resolutions, with starvation protection for updates.
// Ports:
//   clk, reset                                    - clock, async active-low reset
//   lk_valid, lk_index, lk_ready                  - fetch lookup handshake
//   rs_valid, rs_index, rs_outcome, rs_pred,
//   rs_ready                                      - resolution handshake into FIFO
//   pht_en, pht_we, pht_index, pht_outcome        - registered PHT access
//   bhr_shift, bhr_bit                            - registered BHR shift request
//   total_cnt, miss_cnt                           - saturating update statistics
//   busy                                          - resolutions still queued
module bp_update_scheduler
  import bp_sched_pkg::*;
#(
  parameter int unsigned K      = KDef,
  parameter int unsigned M      = MDef,
  parameter int unsigned DEPTH  = DepthDef,
  parameter int unsigned STARVE = StarveDef,
  parameter int unsigned CW     = CwDef
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lk_valid,
  input  logic [K-1:0]  lk_index,
  output logic          lk_ready,
  input  logic          rs_valid,
  input  logic [K-1:0]  rs_index,
  input  logic          rs_outcome,
  input  logic          rs_pred,
  output logic          rs_ready,
  output logic          pht_en,
  output logic          pht_we,
  output logic [K-1:0]  pht_index,
  output logic          pht_outcome,
  output logic          bhr_shift,
  output logic          bhr_bit,
  output logic [CW-1:0] total_cnt,
  output logic [CW-1:0] miss_cnt,
  output logic          busy
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned StW  = $clog2(STARVE + 1);

  // The entry type is sized for the default index width and DEPTH must be a
  // power of two for the pointer wrap to work.
  if (K != KDef || M == 0 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE == 0)
  begin : g_bad_cfg
    $error("bp_update_scheduler: unsupported parameter combination");
  end

  upd_entry_t      push_entry;
  upd_entry_t      head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            push;
  logic            lk_grant;
  logic            upd_grant;

  arb_state_t      state_q;
  arb_state_t      state_d;
  logic [StW-1:0]  starve_q;
  logic [StW-1:0]  starve_d;

  logic            pht_en_q, pht_we_q, pht_outcome_q, bhr_shift_q, bhr_bit_q;
  logic [K-1:0]    pht_index_q;
  logic [CW-1:0]   total_q, miss_q;

  assign push_entry = '{index: rs_index, outcome: rs_outcome, pred: rs_pred};
  assign rs_ready   = ~fifo_full;
  assign push       = rs_valid & rs_ready;
  assign lk_ready   = (state_q == LkPri) | fifo_empty;
  assign busy       = (fifo_count != '0);

  bp_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (upd_grant),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    lk_grant  = lk_valid & lk_ready;
    upd_grant = ~lk_grant & ~fifo_empty;

    starve_d = starve_q;
    if (fifo_empty || upd_grant) begin
      starve_d = '0;
    end else if (lk_grant && starve_q != StW'(STARVE)) begin
      starve_d = starve_q + 1'b1;
    end

    state_d = state_q;
    unique case (state_q)
      LkPri: begin
        if (fifo_full ||
            (lk_grant && !fifo_empty && starve_q == StW'(STARVE - 1))) begin
          state_d = UpdPri;
        end
      end
      UpdPri: begin
        if (upd_grant) state_d = LkPri;
      end
      default: state_d = LkPri;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= LkPri;
      starve_q      <= '0;
      pht_en_q      <= 1'b0;
      pht_we_q      <= 1'b0;
      pht_index_q   <= '0;
      pht_outcome_q <= 1'b0;
      bhr_shift_q   <= 1'b0;
      bhr_bit_q     <= 1'b0;
      total_q       <= '0;
      miss_q        <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      pht_en_q    <= lk_grant | upd_grant;
      bhr_shift_q <= upd_grant;
      if (lk_grant) begin
        pht_we_q    <= 1'b0;
        pht_index_q <= lk_index;
      end else if (upd_grant) begin
        pht_we_q      <= 1'b1;
        pht_index_q   <= head.index;
        pht_outcome_q <= head.outcome;
        bhr_bit_q     <= head.outcome;
        if (total_q != '1) total_q <= total_q + 1'b1;
        if (is_miss(head) && miss_q != '1) miss_q <= miss_q + 1'b1;
      end
    end
  end

  assign pht_en      = pht_en_q;
  assign pht_we      = pht_we_q;
  assign pht_index   = pht_index_q;
  assign pht_outcome = pht_outcome_q;
  assign bhr_shift   = bhr_shift_q;
  assign bhr_bit     = bhr_bit_q;
  assign total_cnt   = total_q;
  assign miss_cnt    = miss_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler with the statistics width reduced to
// 4 bits so that counter saturation is reachable.
module tb_bp_update_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lk_valid = 1'b0;
  logic [3:0] lk_index = '0;
  logic       lk_ready;
  logic       rs_valid = 1'b0;
  logic [3:0] rs_index = '0;
  logic       rs_outcome = 1'b0;
  logic       rs_pred = 1'b0;
  logic       rs_ready;
  logic       pht_en, pht_we, pht_outcome, bhr_shift, bhr_bit, busy;
  logic [3:0] pht_index;
  logic [3:0] total_cnt, miss_cnt;

  int errors = 0;
  int checks = 0;

  bp_update_scheduler #(
    .K      (4),
    .M      (3),
    .DEPTH  (4),
    .STARVE (3),
    .CW     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lk_valid    (lk_valid),
    .lk_index    (lk_index),
    .lk_ready    (lk_ready),
    .rs_valid    (rs_valid),
    .rs_index    (rs_index),
    .rs_outcome  (rs_outcome),
    .rs_pred     (rs_pred),
    .rs_ready    (rs_ready),
    .pht_en      (pht_en),
    .pht_we      (pht_we),
    .pht_index   (pht_index),
    .pht_outcome (pht_outcome),
    .bhr_shift   (bhr_shift),
    .bhr_bit     (bhr_bit),
    .total_cnt   (total_cnt),
    .miss_cnt    (miss_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Registered outputs are read 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    lk_valid = 1'b0;
    rs_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic push(input logic [3:0] idx, input logic out, input logic pred);
    rs_valid   = 1'b1;
    rs_index   = idx;
    rs_outcome = out;
    rs_pred    = pred;
  endtask

  initial begin
    // 1: reset state
    do_reset();
    chk("rst_pht_en", pht_en, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_miss", miss_cnt, 0);
    chk("rst_rs_ready", rs_ready, 1);
    chk("rst_lk_ready", lk_ready, 1);
    chk("rst_busy", busy, 0);

    // 2: single mispredicted resolution, no lookups
    push(4'd5, 1'b1, 1'b0);
    tick();
    rs_valid = 1'b0;
    chk("s2_busy_c1", busy, 1);
    chk("s2_en_c1", pht_en, 0);
    tick();
    chk("s2_en", pht_en, 1);
    chk("s2_we", pht_we, 1);
    chk("s2_idx", pht_index, 5);
    chk("s2_out", pht_outcome, 1);
    chk("s2_shift", bhr_shift, 1);
    chk("s2_bit", bhr_bit, 1);
    chk("s2_total", total_cnt, 1);
    chk("s2_miss", miss_cnt, 1);
    chk("s2_busy", busy, 0);
    tick();
    chk("s2_en_c3", pht_en, 0);
    chk("s2_shift_c3", bhr_shift, 0);
    chk("s2_idx_hold", pht_index, 5);

    // 3: starvation protection, one queued entry vs continuous lookups
    do_reset();
    push(4'd9, 1'b0, 1'b0);
    tick();
    rs_valid = 1'b0;
    lk_valid = 1'b1;
    lk_index = 4'd1;
    #1 chk("s3_rdy_c1", lk_ready, 1);
    tick();
    chk("s3_lk1_we", pht_we, 0);
    chk("s3_lk1_idx", pht_index, 1);
    lk_index = 4'd2;
    #1 chk("s3_rdy_c2", lk_ready, 1);
    tick();
    lk_index = 4'd3;
    #1 chk("s3_rdy_c3", lk_ready, 1);
    tick();
    chk("s3_lk3_idx", pht_index, 3);
    chk("s3_lk3_en", pht_en, 1);
    lk_index = 4'd4;
    #1 chk("s3_rdy_c4", lk_ready, 0);
    chk("s3_busy_c4", busy, 1);
    tick();
    chk("s3_upd_we", pht_we, 1);
    chk("s3_upd_idx", pht_index, 9);
    chk("s3_upd_shift", bhr_shift, 1);
    chk("s3_upd_bit", bhr_bit, 0);
    chk("s3_rdy_c5", lk_ready, 1);
    chk("s3_busy_c5", busy, 0);
    tick();
    chk("s3_resume_en", pht_en, 1);
    chk("s3_resume_we", pht_we, 0);
    chk("s3_resume_idx", pht_index, 4);
    chk("s3_total", total_cnt, 1);
    chk("s3_miss", miss_cnt, 0);

    // 4: fill the FIFO while lookups are pending
    do_reset();
    lk_valid = 1'b1;
    lk_index = 4'd0;
    push(4'd1, 1'b1, 1'b1);
    tick();
    push(4'd2, 1'b1, 1'b1);
    tick();
    push(4'd3, 1'b1, 1'b1);
    tick();
    push(4'd4, 1'b1, 1'b1);
    #1 chk("s4_rdy_c3", lk_ready, 1);
    tick();
    push(4'd5, 1'b1, 1'b1);
    #1 chk("s4_full_rs_ready", rs_ready, 0);
    chk("s4_full_lk_ready", lk_ready, 0);
    chk("s4_full_we", pht_we, 0);
    tick();
    chk("s4_upd1_we", pht_we, 1);
    chk("s4_upd1_idx", pht_index, 1);
    chk("s4_rs_ready_c5", rs_ready, 1);
    tick();
    rs_valid = 1'b0;
    lk_valid = 1'b0;
    chk("s4_lk_c6", pht_we, 0);
    tick();
    chk("s4_idx2", pht_index, 2);
    tick();
    chk("s4_idx3", pht_index, 3);
    tick();
    chk("s4_idx4", pht_index, 4);
    tick();
    chk("s4_idx5", pht_index, 5);
    chk("s4_we5", pht_we, 1);
    chk("s4_busy", busy, 0);
    chk("s4_total", total_cnt, 5);
    chk("s4_miss", miss_cnt, 0);

    // 5: streaming pushes with concurrent pops, strict ordering
    do_reset();
    push(4'd6, 1'b1, 1'b0);
    tick();
    push(4'd7, 1'b0, 1'b0);
    tick();
    push(4'd8, 1'b1, 1'b1);
    chk("s5_busy_c2", busy, 1);
    chk("s5_idx6", pht_index, 6);
    chk("s5_miss6", miss_cnt, 1);
    tick();
    rs_valid = 1'b0;
    chk("s5_busy_c3", busy, 1);
    chk("s5_idx7", pht_index, 7);
    chk("s5_miss7", miss_cnt, 1);
    chk("s5_total7", total_cnt, 2);
    tick();
    chk("s5_idx8", pht_index, 8);
    chk("s5_en8", pht_en, 1);
    chk("s5_miss8", miss_cnt, 1);
    chk("s5_total8", total_cnt, 3);
    chk("s5_busy_c4", busy, 0);

    // 6: counter saturation, then reset during a drain
    do_reset();
    for (int i = 0; i < 20; i++) begin
      push(4'(i), 1'b1, 1'b0);
      tick();
    end
    rs_valid = 1'b0;
    repeat (3) tick();
    chk("s6_miss_sat", miss_cnt, 15);
    chk("s6_total_sat", total_cnt, 15);
    lk_valid = 1'b1;
    lk_index = 4'd3;
    push(4'd10, 1'b1, 1'b0);
    tick();
    push(4'd11, 1'b1, 1'b0);
    tick();
    push(4'd12, 1'b1, 1'b0);
    tick();
    rs_valid = 1'b0;
    chk("s6_busy_q", busy, 1);
    chk("s6_inflight", pht_en, 1);
    reset = 1'b0;
    #1;
    chk("s6_rst_en", pht_en, 0);
    chk("s6_rst_busy", busy, 0);
    chk("s6_rst_total", total_cnt, 0);
    tick();
    tick();
    reset    = 1'b1;
    lk_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("s6_no_issue", pht_en, 0);
    end
    chk("s6_total_after", total_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
Shares the single-ported pattern history table (PHT) and the branch history register (BHR) between two requesters: fetch-stage prediction lookups and execute-stage branch resolutions. Resolutions are buffered in a small FIFO. An arbitration state machine with starvation protection decides, each cycle, whether the PHT port performs a lookup or an update. The block also keeps resolved-branch and misprediction statistics. It sits between the fetch/execute interfaces and the predictor datapath (BHR + PHT).

Parameters:
K, 4, PHT index width
M, 3, BHR history width (passed through to datapath; no internal use beyond package typing)
DEPTH, 4, resolution FIFO entries (power of two, >=2)
STARVE, 3, consecutive lookup grants tolerated while FIFO non-empty before an update is forced
CW, 16, statistics counter width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
lk_valid  in  1  fetch lookup request
lk_index  in  K  lookup PHT index
lk_ready  out  1  lookup accepted this cycle when lk_valid=1
rs_valid  in  1  execute resolution request
rs_index  in  K  resolved branch PHT index
rs_outcome  in  1  actual branch direction
rs_pred  in  1  direction that was predicted for this branch
rs_ready  out  1  resolution accepted into FIFO when rs_valid=1
pht_en  out  1  PHT access strobe (registered)
pht_we  out  1  1=update, 0=lookup (registered)
pht_index  out  K  PHT index (registered)
pht_outcome  out  1  training direction for update (registered)
bhr_shift  out  1  shift BHR this cycle (registered, equals pht_en & pht_we)
bhr_bit  out  1  bit shifted into BHR (registered)
total_cnt  out  CW  resolved branches issued to PHT
miss_cnt  out  CW  issued updates with rs_outcome != rs_pred
busy  out  1  FIFO non-empty

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs 0, counters 0, FIFO empty, state LK_PRI, starve_cnt 0. rs_ready=1 and lk_ready=1 combinationally after reset.
- FIFO: push on rs_valid & rs_ready. rs_ready = !full; a push is refused when full, even in a cycle that pops. A pushed entry can be popped the next cycle at earliest (no bypass). Simultaneous push and pop when not full: occupancy unchanged. Order is strict FIFO. Pointers wrap modulo DEPTH.
- States: LK_PRI and UPD_PRI.
- lk_ready = (state==LK_PRI) | fifo_empty.
- Per cycle grant, in priority order:
  - Lookup if lk_valid & lk_ready.
  - Otherwise update (pop) if FIFO is non-empty.
  - Otherwise idle.
  - At most one grant per cycle.
- Issue latency: the grant in cycle t produces pht_* and bhr_* outputs in cycle t+1 for exactly one cycle.
  - Lookup: pht_en=1, pht_we=0, pht_index=lk_index, bhr_shift=0.
  - Update: pht_en=1, pht_we=1, pht_index/pht_outcome from entry, bhr_shift=1, bhr_bit=outcome.
  - Idle: pht_en=0, bhr_shift=0. Other outputs hold.
- starve_cnt: increments on a lookup grant while FIFO is non-empty. Clears on any update grant or when the FIFO is empty.
- Transitions:
  - LK_PRI -> UPD_PRI when FIFO full, or when a lookup is granted with FIFO non-empty and starve_cnt==STARVE-1.
  - UPD_PRI -> LK_PRI after exactly one update grant.
- Counters update on the update grant cycle (visible t+1). total_cnt increments. miss_cnt increments if outcome!=pred. Both saturate at all-ones and never wrap.
- Reset asserted mid-operation: queued entries are discarded and never issued; any in-flight pht_en drops immediately.

Decomposition:
- Package bp_sched_pkg:
  - arb_state_t enum {LK_PRI, UPD_PRI}.
  - upd_entry_t packed struct {index[K-1:0], outcome, pred}.
  - Default-parameter localparams.
- Sub-module bp_upd_fifo: parameterised DEPTH-entry synchronous FIFO of upd_entry_t. Ports: push, pop, full, empty, count. Same clock and reset.

Test Plan:
1. Reset: hold reset=0 three cycles, then release -> pht_en=0, total_cnt=0, miss_cnt=0, rs_ready=1, lk_ready=1, busy=0.
2. Single resolution, no lookups: cycle 0 rs_valid, index=5, outcome=1, pred=0 -> cycle 2 shows pht_en=1, pht_we=1, pht_index=5, pht_outcome=1, bhr_shift=1, bhr_bit=1; total_cnt=1, miss_cnt=1; busy=0 from cycle 2.
3. Starvation, STARVE=3: one queued entry plus continuous lk_valid -> three lookups granted, then lk_ready=0 for one cycle and the update issues; lookups resume the following cycle.
4. FIFO full: push 4 entries (indices 1,2,3,4) while lk_valid is held high -> rs_ready=0 with 4 queued, state UPD_PRI, update issued for index 1. A 5th push is refused in the full cycle and accepted once rs_ready=1.
5. Ordering and simultaneous push/pop: stream indices 6,7,8 with lk_valid=0 -> updates issue in order 6,7,8. Occupancy stays constant while push and pop coincide. miss_cnt increments only for entries with outcome!=pred.
6. Saturation and reset mid-drain, with CW=4: issue 20 mispredicted updates -> miss_cnt=15, total_cnt=15. Then queue 3 entries and assert reset -> pht_en=0 immediately; after release no update from the discarded entries is ever issued.
